// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Takes one radix-2 step per cycle and stalls the pipeline until the result is ready.
module execute_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Flush_E,
  input  logic            MD_En_E,
  input  logic [2:0]      MD_Op_E,
  input  logic [XLEN-1:0] SrcA_E,
  input  logic [XLEN-1:0] SrcB_E,
  output logic            MD_Stall,
  output logic            MD_Valid_E,
  output logic [XLEN-1:0] MD_Result_E
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_reg;
  logic [4:0]          count_reg;
  logic [2*XLEN-1:0]   work_reg;
  logic [XLEN-1:0]     opnd_reg;
  logic [2:0]          op_reg;
  logic                sign_a_reg;
  logic                sign_b_reg;
  logic [XLEN-1:0]     result_reg;

  // Operand decode for the start cycle
  logic            is_div, signed_a, signed_b, sign_a, sign_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b, special_result;

  assign is_div   = MD_Op_E[2];
  assign signed_a = (MD_Op_E != 3'b011) && (MD_Op_E != 3'b101) && (MD_Op_E != 3'b111);
  assign signed_b = signed_a && (MD_Op_E != 3'b010);
  assign sign_a   = signed_a & SrcA_E[XLEN-1];
  assign sign_b   = signed_b & SrcB_E[XLEN-1];
  assign abs_a    = sign_a ? -SrcA_E : SrcA_E;
  assign abs_b    = sign_b ? -SrcB_E : SrcB_E;
  assign div_zero = is_div && (SrcB_E == '0);
  assign div_ovf  = ((MD_Op_E == 3'b100) || (MD_Op_E == 3'b110)) &&
                    (SrcA_E == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB_E == '1);
  // REM/REMU have op[1] set; they return the remainder flavour of the special case
  assign special_result = div_zero ? (MD_Op_E[1] ? SrcA_E : '1)
                                   : (MD_Op_E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step_next;

  assign mul_sum   = {1'b0, work_reg[2*XLEN-1:XLEN]} + (work_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next  = {mul_sum, work_reg[XLEN-1:1]};
  assign div_diff  = work_reg[2*XLEN-1:XLEN-1] - {1'b0, opnd_reg};
  assign div_next  = div_diff[XLEN] ? {work_reg[2*XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], work_reg[XLEN-2:0], 1'b1};
  assign step_next = op_reg[2] ? div_next : mul_next;

  // Sign fix-up applied to the final step's value
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_raw, rem_raw, quot_fix, rem_fix, final_result;

  assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -step_next : step_next;
  assign quot_raw = step_next[XLEN-1:0];
  assign rem_raw  = step_next[2*XLEN-1:XLEN];
  assign quot_fix = (sign_a_reg ^ sign_b_reg) ? -quot_raw : quot_raw;
  assign rem_fix  = sign_a_reg ? -rem_raw : rem_raw;

  always_comb begin
    final_result = prod_fix[2*XLEN-1:XLEN];
    case (op_reg)
      3'b000:         final_result = prod_fix[XLEN-1:0];
      3'b100, 3'b101: final_result = quot_fix;
      3'b110, 3'b111: final_result = rem_fix;
      default:        final_result = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      work_reg   <= '0;
      opnd_reg   <= '0;
      op_reg     <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      result_reg <= '0;
    end else if (Flush_E) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (MD_En_E) begin
            op_reg     <= MD_Op_E;
            sign_a_reg <= sign_a;
            sign_b_reg <= sign_b;
            if (div_zero || div_ovf) begin
              result_reg <= special_result;
              state_reg  <= DONE;
            end else begin
              work_reg  <= is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
              opnd_reg  <= is_div ? abs_b : abs_a;
              count_reg <= '0;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          work_reg  <= step_next;
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'd31) begin
            result_reg <= final_result;
            state_reg  <= DONE;
          end
        end
        // Leaving DONE unconditionally keeps a still-asserted enable from restarting
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign MD_Stall    = ((state_reg == IDLE) && MD_En_E && !Flush_E) || (state_reg == CALC);
  assign MD_Valid_E  = (state_reg == DONE);
  assign MD_Result_E = result_reg;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_execute_muldiv_unit;

  logic        CLK;
  logic        RST;
  logic        Flush_E;
  logic        MD_En_E;
  logic [2:0]  MD_Op_E;
  logic [31:0] SrcA_E;
  logic [31:0] SrcB_E;
  logic        MD_Stall;
  logic        MD_Valid_E;
  logic [31:0] MD_Result_E;

  int checks;
  int failures;

  execute_muldiv_unit #(.XLEN(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Flush_E     (Flush_E),
    .MD_En_E     (MD_En_E),
    .MD_Op_E     (MD_Op_E),
    .SrcA_E      (SrcA_E),
    .SrcB_E      (SrcB_E),
    .MD_Stall    (MD_Stall),
    .MD_Valid_E  (MD_Valid_E),
    .MD_Result_E (MD_Result_E)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics with plain 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) ||
           (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  // Issue one op, hold enable through DONE, then check result, stall length and a single valid pulse
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp_res, res;
    int          stall_cnt, exp_stall;
    bit          seen;
    logic        stall_in_done;
    exp_res       = ref_md(op, a, b);
    exp_stall     = is_special(op, a, b) ? 1 : 33;
    stall_cnt     = 0;
    seen          = 0;
    res           = '0;
    stall_in_done = 1'b0;
    @(negedge CLK);
    MD_En_E = 1'b1; MD_Op_E = op; SrcA_E = a; SrcB_E = b;
    #1;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (MD_Valid_E) begin
        seen          = 1;
        res           = MD_Result_E;
        stall_in_done = MD_Stall;
      end else begin
        if (MD_Stall) stall_cnt++;
        @(negedge CLK); #1;
      end
    end
    check_value({tag, "_valid"}, 32'(seen), 32'd1);
    check_value({tag, "_result"}, res, exp_res);
    check_value({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    check_value({tag, "_stall_in_done"}, 32'(stall_in_done), 32'd0);
    @(negedge CLK);
    MD_En_E = 1'b0;
    #1;
    check_value({tag, "_single_valid"}, 32'(MD_Valid_E), 32'd0);
    $display("op=%0d a=0x%08h b=0x%08h result=0x%08h exp=0x%08h stall=%0d", op, a, b, res, exp_res, stall_cnt);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'(32'($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int valid_seen;
    checks = 0; failures = 0;
    RST = 1'b0; Flush_E = 1'b0; MD_En_E = 1'b0; MD_Op_E = '0; SrcA_E = '0; SrcB_E = '0;
    repeat (2) @(negedge CLK);
    #1;
    check_value("reset_stall",  32'(MD_Stall),   32'd0);
    check_value("reset_valid",  32'(MD_Valid_E), 32'd0);
    check_value("reset_result", MD_Result_E,     32'd0);
    RST = 1'b1;
    @(negedge CLK); #1;
    check_value("idle_no_en_stall", 32'(MD_Stall), 32'd0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ff");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, "remu_100_7");
    run_op(3'd4, 32'd5, 32'd0, "div_by_zero");
    run_op(3'd6, 32'd5, 32'd0, "rem_by_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Flush in the fifth CALC cycle: stall drops next cycle and no result is ever produced
    @(negedge CLK);
    MD_En_E = 1'b1; MD_Op_E = 3'd0; SrcA_E = 32'd9; SrcB_E = 32'd9;
    repeat (5) @(negedge CLK);
    Flush_E = 1'b1;
    @(negedge CLK);
    Flush_E = 1'b0; MD_En_E = 1'b0;
    #1;
    check_value("flush_stall", 32'(MD_Stall), 32'd0);
    valid_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (MD_Valid_E) valid_seen++;
      @(negedge CLK); #1;
    end
    check_value("flush_no_valid", 32'(valid_seen), 32'd0);
    $display("flush at calc cycle 5: valid pulses=%0d", valid_seen);

    // Reset in the tenth CALC cycle aborts immediately
    @(negedge CLK);
    MD_En_E = 1'b1; MD_Op_E = 3'd3; SrcA_E = 32'h1234_5678; SrcB_E = 32'h9ABC_DEF0;
    repeat (10) @(negedge CLK);
    RST = 1'b0; MD_En_E = 1'b0;
    #1;
    check_value("abort_stall",  32'(MD_Stall),   32'd0);
    check_value("abort_valid",  32'(MD_Valid_E), 32'd0);
    check_value("abort_result", MD_Result_E,     32'd0);
    $display("reset at calc cycle 10: stall=%0d valid=%0d result=0x%08h", MD_Stall, MD_Valid_E, MD_Result_E);
    @(negedge CLK);
    RST = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, "mul_3_4_after_reset");

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
